// File: rtl/pattern_assembler.sv
// pattern_assembler
//   Builds a packed LANES x LANE_W word from a stream of elements, with the
//   semantics of an SV assignment pattern. Keyed mode ('{idx:val, default:d})
//   writes lane[idx]. Positional mode ('{a,b,c}) writes the top lane first and
//   works downwards. Every lane is preloaded with default_val at start. Errors
//   are reported when the assembled word is handed off.
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   start, pos_mode, default_val  begin a pattern (IDLE only); mode and fill latched
//   elem_valid/elem_ready       element handshake; elem_ready is high only in FILL
//   elem_idx, elem_data, elem_last  element key (keyed mode), value, end marker
//   out_valid/out_ready         handshake for the assembled word
//   out_data                    lane k at [k*LANE_W +: LANE_W]
//   err_index, err_count        keyed index out of range / positional count != LANES

module pattern_lane #(
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_def,
  input  logic [LANE_W-1:0] def_val,
  input  logic              wr,
  input  logic [LANE_W-1:0] data,
  output logic [LANE_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)        q <= '0;
    else if (load_def) q <= def_val;
    else if (wr)       q <= data;
  end
endmodule

module pattern_assembler #(
  parameter int LANES  = 4,
  parameter int LANE_W = 64,
  parameter int IDX_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    pos_mode,
  input  logic [LANE_W-1:0]       default_val,
  input  logic                    elem_valid,
  output logic                    elem_ready,
  input  logic [IDX_W-1:0]        elem_idx,
  input  logic [LANE_W-1:0]       elem_data,
  input  logic                    elem_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    err_index,
  output logic                    err_count
);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] data;
    logic              last;
  } elem_t;

  state_t state, state_n;
  elem_t  elem;
  logic   pos_q;
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;   // saturates at LANES; extra positional elements are dropped
  logic   hs, load_def, keyed_ok, pos_ok;
  logic [LANES-1:0][LANE_W-1:0] lanes;

  assign elem     = '{idx: elem_idx, data: elem_data, last: elem_last};
  assign hs       = elem_valid & elem_ready;
  assign load_def = (state == IDLE) & start;
  assign keyed_ok = elem.idx < IDX_W'(LANES);
  assign pos_ok   = count < CW'(LANES);
  assign out_data = lanes;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)           state_n = FILL;
      FILL:    if (hs && elem.last) state_n = OUT;
      OUT:     if (out_ready)       state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic wr;
    // An out-of-range key or an overflowing positional element matches no lane.
    assign wr = hs & (pos_q ? (pos_ok && ptr == PW'(k)) : (elem.idx == IDX_W'(k)));
    pattern_lane #(.LANE_W(LANE_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_def (load_def),
      .def_val  (default_val),
      .wr       (wr),
      .data     (elem.data),
      .q        (lanes[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      elem_ready <= 1'b0;
      out_valid  <= 1'b0;
      err_index  <= 1'b0;
      err_count  <= 1'b0;
      pos_q      <= 1'b0;
      ptr        <= PW'(LANES - 1);
      count      <= '0;
    end else begin
      state      <= state_n;
      // Registered copies of the next state so the handshake outputs are glitch-free.
      elem_ready <= (state_n == FILL);
      out_valid  <= (state_n == OUT);
      if (load_def) begin
        pos_q     <= pos_mode;
        ptr       <= PW'(LANES - 1);
        count     <= '0;
        err_index <= 1'b0;
        err_count <= 1'b0;
      end
      if (hs) begin
        if (pos_q) begin
          if (pos_ok) begin
            ptr   <= ptr - PW'(1);
            count <= count + CW'(1);
            // Ending before the last lane is filled: short pattern.
            if (elem.last && count != CW'(LANES - 1)) err_count <= 1'b1;
          end else begin
            err_count <= 1'b1;
          end
        end else if (!keyed_ok) begin
          err_index <= 1'b1;
        end
      end
    end
  end
endmodule
